alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Drives the 4-bit nibble ALU through one complete 8-bit arithmetic/logic operation.
- Sequence per operation: load operand A, load operand B and compute the low nibble, compute the high nibble, then register the result and Z/N/H/C flags.
- Sits between the CPU microcode decoder (req/ack side) and the ALU control lines. Owns the half-carry latch between the nibble cycles.

Parameters:
- none (8-bit datapath, 4-bit ALU fixed)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  start operation; sampled only when ready=1
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- opa  in  8  operand A
- opb  in  8  operand B
- cin  in  1  carry flag input (used by ADC/SBC only)
- ready  out  1  idle or done; can accept req
- done  out  1  one-cycle pulse: res/flags updated this cycle
- res  out  8  registered result
- res_we  out  1  with done; 0 for CP, 1 otherwise
- flag_z, flag_n, flag_h, flag_c  out  1 each  registered flags
- alu_bus  out  8  operand driven to ALU op bus
- alu_la, alu_lb  out  1 each  bus-load strobes for the A and B nibble registers
- alu_res_oe  out  1  ALU result output enable (vs shifter path)
- alu_r, alu_s, alu_v, alu_ne  out  1 each  function select
- alu_ci  out  1  nibble carry in
- alu_l, alu_h  out  1 each  low/high nibble select
- alu_result  in  8  ALU result
- alu_carry  in  1  nibble carry; for subtract ops it is the borrow (active-low carry)
- alu_zero  in  1  ALU zero detect, valid in the high cycle

Behaviour:
- Reset: state=IDLE; ready=1, done=0, res_we=0, res=0, flags=0, all alu_* strobes 0, alu_bus=0, half-carry latch=0.
- FSM states: IDLE, LDA, LOW, HIGH, DONE.
  - IDLE or DONE with req=1: capture op/opa/opb/cin, go to LDA. Otherwise IDLE.
  - LDA: alu_bus=opa, alu_la=1. Go to LOW.
  - LOW: alu_bus=opb, alu_lb=1, alu_l=1, alu_res_oe=1. Carry in applied here. Latch hc=alu_carry at the clock edge. Go to HIGH.
  - HIGH: alu_h=1, alu_res_oe=1, alu_ci=hc. Register res=alu_result, Z=alu_zero, C=alu_carry (arith). Go to DONE.
  - DONE: done=1, ready=1. Go to IDLE, or to LDA on req.
- Latency: req accepted at edge N; done=1 in cycle N+4. Back-to-back throughput is one op per 4 cycles.
- ready=1 only in IDLE/DONE. A req while busy is ignored and not queued.
- Function select:
  - ADD/ADC: r=s=v=0, ne=0.
  - SUB/SBC/CP: ne=1.
  - AND: r=1.
  - XOR: s=1.
  - OR: r=1, s=1.
  - Unused select bits are 0.
- Low-cycle alu_ci:
  - ADD: 0.
  - ADC: cin.
  - SUB/CP: 1.
  - SBC: !cin.
  - Logic ops: 0.
- Flags:
  - N=1 for SUB/SBC/CP, else 0.
  - Arith: H=hc, C=alu_carry from HIGH.
  - AND: H=1, C=0.
  - XOR/OR: H=0, C=0.
  - Z from alu_zero for all ops.
- CP: flags updated, res_we=0, res still holds the difference.
- Inputs are captured at acceptance; changes to opa/opb/op/cin mid-operation have no effect.
- Reset in any state: return to IDLE next cycle. No done pulse; res/flags cleared.
- Outside their states, all alu_* strobes are 0 and alu_bus=0.

Test Plan:
- ADD 0x3A+0xC6 -> done at cycle+4; res=0x00, Z=1, N=0, H=1, C=1, res_we=1.
- SBC 0x10-0x01 with cin=1 -> res=0x0E, Z=0, N=1, H=1, C=0.
- CP 0x05 vs 0x07 -> res_we=0, Z=0, N=1, H=1, C=1. Sequence LDA/LOW/HIGH/DONE exactly: alu_la only in LDA, alu_lb only in LOW.
- AND 0xF0&0x0F -> res=0x00, Z=1, H=1, C=0; alu_r=1, alu_s=0, alu_ne=0.
- Back-to-back: req held high during DONE -> second op enters LDA immediately. A req pulse in LOW is ignored (no extra done).
- Reset asserted in HIGH -> next cycle IDLE, ready=1, done=0, res=0, flags=0. A subsequent ADD 0x01+0x01 gives res=0x02.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences one 8-bit ALU operation through the 4-bit nibble ALU.
// It loads A, then loads B and computes the low nibble, then computes the high nibble and registers the result and flags.
//
// state | meaning
// IDLE  | waiting for req, ready=1
// LDA   | operand A on alu_bus, alu_la strobe
// LOW   | operand B on alu_bus, alu_lb strobe, low nibble computed, carry latched
// HIGH  | high nibble computed with latched carry, result/flags registered
// DONE  | done pulse, ready=1, may accept the next req
module alu_op_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] op,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    input  logic       cin,
    output logic       ready,
    output logic       done,
    output logic [7:0] res,
    output logic       res_we,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_h,
    output logic       flag_c,
    output logic [7:0] alu_bus,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_res_oe,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [2:0] {IDLE, LDA, LOW, HIGH, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic       cin_q;
    logic       hc;
    logic       accept;
    logic       is_sub, is_arith;
    logic       fn_r, fn_s, fn_ne, lo_ci;

    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    assign is_arith = is_sub || (op_q == OP_ADD) || (op_q == OP_ADC);

    // Function select and low-nibble carry-in depend only on the captured op.
    always_comb begin
        fn_r  = 1'b0;
        fn_s  = 1'b0;
        fn_ne = 1'b0;
        lo_ci = 1'b0;
        case (op_q)
            OP_ADD: lo_ci = 1'b0;
            OP_ADC: lo_ci = cin_q;
            OP_SUB: begin fn_ne = 1'b1; lo_ci = 1'b1;   end
            OP_SBC: begin fn_ne = 1'b1; lo_ci = ~cin_q; end
            OP_CP:  begin fn_ne = 1'b1; lo_ci = 1'b1;   end
            OP_AND: fn_r = 1'b1;
            OP_XOR: fn_s = 1'b1;
            OP_OR:  begin fn_r = 1'b1; fn_s = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= 3'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            cin_q  <= 1'b0;
            hc     <= 1'b0;
            res    <= 8'd0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_h <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op;
                a_q   <= opa;
                b_q   <= opb;
                cin_q <= cin;
            end
            if (state == LOW)
                hc <= alu_carry;
            if (state == HIGH) begin
                res    <= alu_result;
                flag_z <= alu_zero;
                flag_n <= is_sub;
                flag_h <= is_arith ? hc : (op_q == OP_AND);
                flag_c <= is_arith ? alu_carry : 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        res_we     = 1'b0;
        alu_bus    = 8'd0;
        alu_la     = 1'b0;
        alu_lb     = 1'b0;
        alu_res_oe = 1'b0;
        alu_r      = 1'b0;
        alu_s      = 1'b0;
        alu_v      = 1'b0;
        alu_ne     = 1'b0;
        alu_ci     = 1'b0;
        alu_l      = 1'b0;
        alu_h      = 1'b0;
        case (state)
            IDLE: begin
                ready     = 1'b1;
                accept    = req;
                state_nxt = req ? LDA : IDLE;
            end
            LDA: begin
                alu_bus   = a_q;
                alu_la    = 1'b1;
                state_nxt = LOW;
            end
            LOW: begin
                alu_bus    = b_q;
                alu_lb     = 1'b1;
                alu_l      = 1'b1;
                alu_res_oe = 1'b1;
                alu_r      = fn_r;
                alu_s      = fn_s;
                alu_ne     = fn_ne;
                alu_ci     = lo_ci;
                state_nxt  = HIGH;
            end
            HIGH: begin
                alu_h      = 1'b1;
                alu_res_oe = 1'b1;
                alu_r      = fn_r;
                alu_s      = fn_s;
                alu_ne     = fn_ne;
                alu_ci     = hc;
                state_nxt  = DONE;
            end
            DONE: begin
                done      = 1'b1;
                ready     = 1'b1;
                res_we    = (op_q != OP_CP);
                accept    = req;
                state_nxt = req ? LDA : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a nibble-ALU stand-in feeds the DUT.
// Each operation's result and flags are compared with whole-byte arithmetic.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [2:0] op;
    logic [7:0] opa, opb;
    logic       cin;
    logic       ready, done, res_we;
    logic [7:0] res;
    logic       flag_z, flag_n, flag_h, flag_c;
    logic [7:0] alu_bus;
    logic       alu_la, alu_lb, alu_res_oe;
    logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
    logic [7:0] alu_result;
    logic       alu_carry, alu_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .opa(opa), .opb(opb),
        .cin(cin), .ready(ready), .done(done), .res(res), .res_we(res_we),
        .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c),
        .alu_bus(alu_bus), .alu_la(alu_la), .alu_lb(alu_lb),
        .alu_res_oe(alu_res_oe), .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v),
        .alu_ne(alu_ne), .alu_ci(alu_ci), .alu_l(alu_l), .alu_h(alu_h),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    // Nibble ALU stand-in. In subtract mode alu_carry is a borrow. The chained
    // high-nibble carry-in takes that same borrow polarity. The low-cycle carry-in is a true carry.
    logic [7:0] stub_a, stub_b, b_cur;
    logic [3:0] stub_lo, an, bn, nib;
    logic [4:0] sum5;
    logic       cy, ci_eff;

    always @(posedge clk) begin
        if (alu_la) stub_a <= alu_bus;
        if (alu_lb) stub_b <= alu_bus;
        if (alu_l)  stub_lo <= nib;
    end

    always_comb begin
        b_cur  = alu_lb ? alu_bus : stub_b;
        an     = alu_h ? stub_a[7:4] : stub_a[3:0];
        bn     = alu_h ? b_cur[7:4] : b_cur[3:0];
        ci_eff = alu_ci;
        sum5   = 5'd0;
        nib    = 4'd0;
        cy     = 1'b0;
        if (alu_ne) begin
            ci_eff = alu_h ? ~alu_ci : alu_ci;
            sum5   = {1'b0, an} + {1'b0, ~bn} + {4'd0, ci_eff};
            nib    = sum5[3:0];
            cy     = ~sum5[4];
        end else begin
            case ({alu_r, alu_s})
                2'b00: begin
                    sum5 = {1'b0, an} + {1'b0, bn} + {4'd0, alu_ci};
                    nib  = sum5[3:0];
                    cy   = sum5[4];
                end
                2'b10:   nib = an & bn;
                2'b01:   nib = an ^ bn;
                default: nib = an | bn;
            endcase
        end
    end

    assign alu_result = {nib, stub_lo};
    assign alu_carry  = cy;
    assign alu_zero   = ({nib, stub_lo} == 8'd0);

    typedef struct packed {
        logic       we;
        logic       z, n, h, c;
        logic [7:0] r;
    } exp_t;

    function automatic exp_t ref_op(input logic [2:0] o, input logic [7:0] a,
                                    input logic [7:0] b, input logic c);
        exp_t e;
        int   ai, bi, ci, s;
        ai = int'(a);
        bi = int'(b);
        ci = (o == 3'd1 || o == 3'd3) ? int'(c) : 0;
        e  = '0;
        case (o)
            3'd0, 3'd1: begin
                s   = ai + bi + ci;
                e.r = s[7:0];
                e.h = ((ai % 16) + (bi % 16) + ci) > 15;
                e.c = s > 255;
            end
            3'd2, 3'd3, 3'd7: begin
                s   = ai - bi - ci;
                e.r = s[7:0];
                e.n = 1'b1;
                e.h = (ai % 16) < ((bi % 16) + ci);
                e.c = ai < (bi + ci);
            end
            3'd4: begin e.r = a & b; e.h = 1'b1; end
            3'd5: e.r = a ^ b;
            default: e.r = a | b;
        endcase
        e.z  = (e.r == 8'd0);
        e.we = (o != 3'd7);
        return e;
    endfunction

    // {r, s, v, ne} for each op
    function automatic logic [3:0] ref_fsel(input logic [2:0] o);
        case (o)
            3'd0, 3'd1:       return 4'b0000;
            3'd2, 3'd3, 3'd7: return 4'b0001;
            3'd4:             return 4'b1000;
            3'd5:             return 4'b0100;
            default:          return 4'b1100;
        endcase
    endfunction

    function automatic logic ref_lo_ci(input logic [2:0] o, input logic c);
        case (o)
            3'd1:       return c;
            3'd2, 3'd7: return 1'b1;
            3'd3:       return ~c;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called one step after an edge while ready; returns in the DONE cycle
    // (or in the cycle after reset when rst_high is set).
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input bit poke_low, input bit rst_high);
        exp_t       e;
        logic [3:0] fs;
        e  = ref_op(o, a, b, c);
        fs = ref_fsel(o);
        chk("ready_before", ready, 1);
        req = 1'b1; op = o; opa = a; opb = b; cin = c;
        @(posedge clk); #1;
        req = 1'b0; op = 3'($urandom); opa = 8'($urandom); opb = 8'($urandom); cin = 1'($urandom);
        chk("lda_la", alu_la, 1);
        chk("lda_lb", alu_lb, 0);
        chk("lda_bus", alu_bus, a);
        chk("lda_busy", {ready, done, alu_l, alu_h}, 0);
        @(posedge clk); #1;
        chk("low_strobes", {alu_la, alu_lb, alu_l, alu_h, alu_res_oe}, 5'b01101);
        chk("low_bus", alu_bus, b);
        chk("low_ci", alu_ci, ref_lo_ci(o, c));
        chk("low_fsel", {alu_r, alu_s, alu_v, alu_ne}, fs);
        if (poke_low) begin
            req = 1'b1; opa = 8'($urandom); opb = 8'($urandom);
        end
        @(posedge clk); #1;
        req = 1'b0;
        chk("high_strobes", {alu_la, alu_lb, alu_l, alu_h, alu_res_oe}, 5'b00011);
        chk("high_fsel", {alu_r, alu_s, alu_v, alu_ne}, fs);
        chk("high_busy", {ready, done}, 0);
        if (fs[0] || o == 3'd0 || o == 3'd1)
            chk("high_ci", alu_ci, e.h);
        if (rst_high) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("rst_ready_done", {ready, done, res_we}, 3'b100);
            chk("rst_res", res, 0);
            chk("rst_flags", {flag_z, flag_n, flag_h, flag_c}, 0);
            chk("rst_alu", {alu_bus, alu_la, alu_lb, alu_l, alu_h, alu_res_oe}, 0);
            return;
        end
        @(posedge clk); #1;
        chk("done_pulse", {done, ready}, 2'b11);
        chk("done_res", res, e.r);
        chk("done_flags", {flag_z, flag_n, flag_h, flag_c}, {e.z, e.n, e.h, e.c});
        chk("done_res_we", res_we, e.we);
        chk("done_alu_idle", {alu_bus, alu_la, alu_lb, alu_l, alu_h, alu_res_oe}, 0);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        chk("idle_no_done", {done, res_we}, 0);
        chk("idle_ready", ready, 1);
        chk("idle_no_lda", alu_la, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 1'b0; op = 3'd0; opa = 8'd0; opb = 8'd0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {ready, done, res_we}, 3'b100);
        chk("reset_res", res, 0);
        chk("reset_flags", {flag_z, flag_n, flag_h, flag_c}, 0);
        chk("reset_alu", {alu_bus, alu_la, alu_lb, alu_l, alu_h, alu_res_oe,
                          alu_r, alu_s, alu_v, alu_ne, alu_ci}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);   // ADD, wraps to zero
        do_op(3'd3, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);   // SBC issued from DONE
        idle_check();
        do_op(3'd7, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);   // CP with stray req in LOW
        idle_check();
        do_op(3'd4, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);   // AND
        idle_check();
        do_op(3'd0, 8'h55, 8'h66, 1'b0, 1'b0, 1'b1);   // reset during HIGH
        do_op(3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_check();

        for (int i = 0; i < 80; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1)
                idle_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
